// File: rtl/mha_pkg.sv
// mha_pkg: shared MHA datapath types and Q2.13 format constants
package mha_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 13;
  typedef enum logic [2:0] {IDLE, WAIT, CAPTURE, DRAIN, CLR} sa_drain_state_t;
endpackage

// File: rtl/sa_drain_if.sv
// sa_drain_if: row stream from sa_drain to the softmax stage; O_ROW_MAX only with SA_DRAIN_ROW_MAX_EN
interface sa_drain_if #(parameter int D_W = 16, SA_R = 16, SA_C = 16);
  localparam int RW = $clog2(SA_R);
  logic O_VLD, I_RDY, O_LAST;
  logic [SA_C-1:0][D_W-1:0] O_ROW;
  logic [RW-1:0] O_ROW_IDX;
`ifdef SA_DRAIN_ROW_MAX_EN
  logic [D_W-1:0] O_ROW_MAX;
  modport master(output O_VLD, O_ROW, O_ROW_IDX, O_LAST, O_ROW_MAX, input I_RDY);
  modport slave(input O_VLD, O_ROW, O_ROW_IDX, O_LAST, O_ROW_MAX, output I_RDY);
`else
  modport master(output O_VLD, O_ROW, O_ROW_IDX, O_LAST, input I_RDY);
  modport slave(input O_VLD, O_ROW, O_ROW_IDX, O_LAST, output I_RDY);
`endif
endinterface

// File: rtl/sa_row_max.sv
// sa_row_max: combinational signed maximum over one row of SA_C words
module sa_row_max #(parameter int D_W = 16, SA_C = 16)(
  input  logic [SA_C-1:0][D_W-1:0] I_ROW,
  output logic [D_W-1:0]           O_MAX
);
  // keep the larger signed word while walking the row
  always_comb begin
    O_MAX = I_ROW[0];
    for (int i = 1; i < SA_C; i++) O_MAX = ($signed(I_ROW[i]) > $signed(O_MAX)) ? I_ROW[i] : O_MAX;
  end
endmodule

// File: rtl/sa_drain.sv
// sa_drain: counts SA shifts per tile, snapshots the result matrix and streams it out row by row; SA_DRAIN_ROW_MAX_EN adds O_ROW_MAX
module sa_drain import mha_pkg::*; #(
  parameter int D_W = DATA_W, SA_R = 16, SA_C = 16, K_W = 8
)(
  input  logic                             I_CLK,
  input  logic                             I_ASYN_RSTN,
  input  logic                             I_SYNC_RSTN,
  input  logic                             I_START,
  input  logic [K_W-1:0]                   I_K,
  input  logic                             I_SHIFT,
  input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] I_SA_OUT,
  output logic                             O_BUSY,
  output logic                             O_SA_CLR,
  output logic                             O_DONE,
  sa_drain_if.master                       row_if
);
  localparam int CW = K_W + $clog2(SA_R + SA_C) + 1;
  localparam int RW = $clog2(SA_R);
  sa_drain_state_t state_q, state_d;
  logic [K_W-1:0] k_q;
  logic [CW-1:0] cnt_q;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] snap_q;
  logic [SA_C-1:0][D_W-1:0] row_q;
  logic [RW-1:0] ptr_q, ptr_n;
  logic vld_q, busy_q, clr_q, xfer, last_row, hit;
  assign xfer = vld_q && row_if.I_RDY;
  assign last_row = ptr_q == RW'(SA_R - 1);
  assign ptr_n = last_row ? '0 : ptr_q + RW'(1);
  // the last product lands on the shift that brings the count to I_K + SA_R + SA_C - 1
  assign hit = I_SHIFT && (cnt_q + CW'(1) == CW'(k_q) + CW'(SA_R + SA_C - 1));
  assign O_BUSY = busy_q;
  assign O_SA_CLR = clr_q;
  assign O_DONE = clr_q;
  assign row_if.O_VLD = vld_q;
  assign row_if.O_ROW = row_q;
  assign row_if.O_ROW_IDX = ptr_q;
  assign row_if.O_LAST = vld_q && last_row;
`ifdef SA_DRAIN_ROW_MAX_EN
  sa_row_max #(.D_W(D_W), .SA_C(SA_C)) u_row_max (.I_ROW(row_q), .O_MAX(row_if.O_ROW_MAX));
`endif
  // tile sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (I_START) state_d = (I_K == '0) ? CAPTURE : WAIT;
      WAIT:    if (hit) state_d = CAPTURE;
      CAPTURE: state_d = DRAIN;
      DRAIN:   if (xfer && last_row) state_d = CLR;
      default: state_d = IDLE;
    endcase
  end
  // state register; sync reset behaves like the async one at the edge
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) state_q <= IDLE;
    else state_q <= I_SYNC_RSTN ? state_d : IDLE;
  // counter, snapshot and registered outputs
  always_ff @(posedge I_CLK or negedge I_ASYN_RSTN)
    if (!I_ASYN_RSTN) begin
      k_q <= '0;
      cnt_q <= '0;
      snap_q <= '0;
      row_q <= '0;
      ptr_q <= '0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
      clr_q <= 1'b0;
    end else if (!I_SYNC_RSTN) begin
      k_q <= '0;
      cnt_q <= '0;
      snap_q <= '0;
      row_q <= '0;
      ptr_q <= '0;
      vld_q <= 1'b0;
      busy_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      busy_q <= state_d != IDLE;
      vld_q <= state_d == DRAIN;
      clr_q <= state_d == CLR;
      if (state_q == IDLE && I_START) k_q <= I_K;
      if (state_q == WAIT && I_SHIFT) cnt_q <= cnt_q + CW'(1);
      if (state_q == CLR) begin
        cnt_q <= '0;
        ptr_q <= '0;
      end
      if (state_q == CAPTURE) begin
        snap_q <= I_SA_OUT;
        row_q <= I_SA_OUT[0];
        ptr_q <= '0;
      end
      if (xfer) begin
        ptr_q <= ptr_n;
        row_q <= snap_q[ptr_n];
      end
    end
endmodule

// File: tb/tb_sa_drain.sv
// tb_sa_drain: directed tiles with a scoreboard of expected rows checked by a decoupled monitor
module tb_sa_drain;
  localparam int SA_R = 4, SA_C = 4, D_W = 16;
  typedef struct packed {logic [63:0] row; logic [1:0] idx; logic last; logic [15:0] mx;} beat_t;
  logic I_CLK = 0, I_ASYN_RSTN = 0, I_SYNC_RSTN = 1, I_START = 0, I_SHIFT = 0;
  logic [7:0] I_K = '0;
  logic [SA_R-1:0][SA_C-1:0][D_W-1:0] I_SA_OUT = '0;
  logic O_BUSY, O_SA_CLR, O_DONE;
  int checks = 0, errors = 0;
  beat_t exp_q[$];
  logic prev_stall = 0, clr_exp = 0;
  logic [63:0] prev_row;
  logic [1:0] prev_idx;
  logic [15:0] spec_m [4][4] = '{'{16'hE000, 16'h0800, 16'h7FFF, 16'h8000},
                                 '{16'hF000, 16'hF000, 16'hF000, 16'hF000},
                                 '{16'h8000, 16'h8001, 16'h8002, 16'h8003},
                                 '{16'h0000, 16'hFFFF, 16'h0001, 16'h8000}};
  logic [15:0] spec_mx [4] = '{16'h7FFF, 16'hF000, 16'h8003, 16'h0001};
  sa_drain_if #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C)) row_if ();
  sa_drain #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_W(8)) dut (
    .I_CLK(I_CLK), .I_ASYN_RSTN(I_ASYN_RSTN), .I_SYNC_RSTN(I_SYNC_RSTN), .I_START(I_START),
    .I_K(I_K), .I_SHIFT(I_SHIFT), .I_SA_OUT(I_SA_OUT), .O_BUSY(O_BUSY), .O_SA_CLR(O_SA_CLR),
    .O_DONE(O_DONE), .row_if(row_if)
  );
  always #5 I_CLK = ~I_CLK;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge I_CLK);
    #1;
  endtask
  function automatic logic [15:0] word(input logic [3:0] t, input int r, input int c);
    if (t == 4'h0) return '0;
    if (t == 4'hE) return spec_m[r][c];
    return {t, 4'(r), 4'(c), 4'h5};
  endfunction
  task automatic set_pat(input logic [3:0] t);
    for (int r = 0; r < SA_R; r++)
      for (int c = 0; c < SA_C; c++) I_SA_OUT[r][c] = word(t, r, c);
  endtask
  function automatic beat_t exp_beat(input logic [3:0] t, input int r);
    beat_t b;
    for (int c = 0; c < SA_C; c++) b.row[c*16 +: 16] = word(t, r, c);
    b.idx = 2'(r);
    b.last = r == SA_R - 1;
    b.mx = (t == 4'hE) ? spec_mx[r] : word(t, r, SA_C - 1);
    return b;
  endfunction
  // monitor: stall stability, beat order/data against the scoreboard, clear pulse after the last beat
  always @(negedge I_CLK) if (I_ASYN_RSTN && I_SYNC_RSTN) begin
    if (prev_stall && row_if.O_VLD) begin
      check("stall_row", row_if.O_ROW, prev_row);
      check("stall_idx", 64'(row_if.O_ROW_IDX), 64'(prev_idx));
    end
    if (clr_exp || O_SA_CLR || O_DONE) check("clr_done", {O_SA_CLR, O_DONE}, {clr_exp, clr_exp});
    if (row_if.O_VLD && row_if.I_RDY) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat idx=%0d row=%0h with empty scoreboard", row_if.O_ROW_IDX, row_if.O_ROW);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_row", row_if.O_ROW, e.row);
        check("beat_idx", 64'(row_if.O_ROW_IDX), 64'(e.idx));
        check("beat_last", 64'(row_if.O_LAST), 64'(e.last));
`ifdef SA_DRAIN_ROW_MAX_EN
        check("row_max", 64'(row_if.O_ROW_MAX), 64'(e.mx));
`endif
      end
    end
    clr_exp <= row_if.O_VLD && row_if.I_RDY && row_if.O_LAST;
    prev_stall <= row_if.O_VLD && !row_if.I_RDY;
    prev_row <= row_if.O_ROW;
    prev_idx <= row_if.O_ROW_IDX;
  end
  task automatic check_quiet(input string nm);
    check({nm, "_vld"}, 64'(row_if.O_VLD), 0);
    check({nm, "_busy"}, 64'(O_BUSY), 0);
    check({nm, "_row"}, row_if.O_ROW, 0);
    check({nm, "_idx"}, 64'(row_if.O_ROW_IDX), 0);
    check({nm, "_last"}, 64'(row_if.O_LAST), 0);
    check({nm, "_clr"}, {O_SA_CLR, O_DONE}, 0);
`ifdef SA_DRAIN_ROW_MAX_EN
    check({nm, "_max"}, 64'(row_if.O_ROW_MAX), 0);
`endif
  endtask
  task automatic run_tile(input int k, input logic [3:0] t, input bit stall, input bit disturb, input bit abort);
    int n, j;
    n = (k == 0) ? 0 : k + SA_R + SA_C - 1;
    set_pat(t);
    for (int r = 0; r < (abort ? 2 : SA_R); r++) exp_q.push_back(exp_beat(t, r));
    row_if.I_RDY = 1;
    if (disturb) repeat (3) begin
      I_SHIFT = 1;
      tick;
      I_SHIFT = 0;
      tick;
    end
    I_K = 8'(k);
    I_START = 1;
    tick;
    I_START = 0;
    I_K = '0;
    check("busy_after_start", 64'(O_BUSY), 1);
    for (int i = 1; i <= n; i++) begin
      I_SHIFT = 1;
      if (disturb && i == 4) I_START = 1;
      tick;
      I_SHIFT = 0;
      I_START = 0;
      if (i == n) break;
      repeat (4) tick;
      if (i == n - 1) check("wait_busy_no_vld", {O_BUSY, row_if.O_VLD}, 2'b10);
    end
    check("capture_no_vld", 64'(row_if.O_VLD), 0);
    tick;
    check("first_vld", 64'(row_if.O_VLD), 1);
    set_pat(t ^ 4'hF);
    if (abort) begin
      repeat (2) tick;
      I_SYNC_RSTN = 0;
      row_if.I_RDY = 0;
      tick;
      I_SYNC_RSTN = 1;
      check_quiet("sync_rst");
      check("abort_queue_empty", 64'(exp_q.size()), 0);
      row_if.I_RDY = 1;
    end else begin
      j = 0;
      while (O_BUSY && j < 40) begin
        row_if.I_RDY = stall ? (j % 3 == 0) : 1'b1;
        tick;
        j++;
      end
      row_if.I_RDY = 1;
      check("tile_idle", 64'(O_BUSY), 0);
      check("drain_cycles", 64'(j), stall ? 11 : 5);
      check("queue_empty", 64'(exp_q.size()), 0);
    end
    tick;
  endtask
  initial begin
    row_if.I_RDY = 1;
    repeat (3) tick;
    check_quiet("async_rst");
    I_ASYN_RSTN = 1;
    tick;
    check_quiet("post_rst");
    run_tile(3, 4'h1, 0, 0, 0);
    run_tile(3, 4'h2, 1, 0, 0);
    run_tile(0, 4'h0, 0, 0, 0);
    run_tile(3, 4'h3, 0, 1, 0);
    run_tile(3, 4'h4, 0, 0, 1);
    run_tile(3, 4'h5, 0, 0, 0);
    run_tile(1, 4'hE, 1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sa_drain.md
# sa_drain

Output drain for the output-stationary systolic array (SA) in the MHA datapath. It counts the SA's shift pulses for a tile of inner dimension I_K, snapshots the full SA_R x SA_C result matrix once the last product has landed, and streams it out one row per beat over a valid/ready handshake. It then pulses a clear so the SA can be synchronously reset for the next tile. It sits between the SA result outputs and the downstream softmax/accumulate stage.

## Interface
- D_W, 16, data width (Q2.13 signed: 1 sign bit, 2 integer bits, 13 fraction bits)
- SA_R, 16, SA rows
- SA_C, 16, SA columns
- K_W, 8, width of the inner-dimension count
- I_CLK  in  1  clock; all logic on posedge
- I_ASYN_RSTN  in  1  asynchronous, active-low reset
- I_SYNC_RSTN  in  1  synchronous active-low reset; same effect as async reset, taken at the clock edge
- I_START  in  1  one-cycle pulse; starts a tile and latches I_K
- I_K  in  K_W  inner dimension of the tile (number of x/w pairs per PE)
- I_SHIFT  in  1  SA shift pulse (SA O_SHIFT)
- I_SA_OUT  in  D_W x [SA_R][SA_C]  SA result matrix
- O_BUSY  out  1  high from the cycle after an accepted I_START through the CLR cycle
- O_VLD  out  1  row valid
- I_RDY  in  1  downstream ready
- O_ROW  out  D_W x [SA_C]  current row
- O_ROW_IDX  out  $clog2(SA_R)  index of current row
- O_LAST  out  1  O_VLD and O_ROW_IDX == SA_R-1
- O_SA_CLR  out  1  one-cycle pulse; the top level drives SA I_SYNC_RSTN low with it
- O_DONE  out  1  one-cycle pulse, coincident with O_SA_CLR

## Operation
- States: IDLE, WAIT, CAPTURE, DRAIN, CLR.
- IDLE:
  - I_START moves to WAIT and latches I_K.
  - If the latched I_K == 0, I_START moves directly to CAPTURE; the snapshot holds whatever the SA shows, which is 0 after a clear.
- WAIT:
  - A shift counter of width K_W+$clog2(SA_R+SA_C)+1 increments on each sampled I_SHIFT.
  - When the count reaches N = I_K + SA_R + SA_C - 1, the next state is CAPTURE.
  - I_SHIFT is ignored in every state except WAIT.
- CAPTURE: one cycle. Load all SA_R x SA_C words of I_SA_OUT into the snapshot buffer, set the row pointer to 0, go to DRAIN.
- DRAIN:
  - O_VLD = 1; O_ROW = snapshot row at the row pointer.
  - A transfer happens when O_VLD && I_RDY; the row pointer then increments.
  - O_ROW, O_ROW_IDX and O_LAST hold stable while O_VLD && !I_RDY.
  - After the transfer with O_LAST = 1, go to CLR.
- CLR: one cycle. O_SA_CLR = 1, O_DONE = 1. The row pointer and shift counter clear; go to IDLE.
- I_START while O_BUSY is ignored; no queuing.
- Data passes through unmodified. There is no arithmetic on data except the optional row max.
- Reset (async or sync, including mid-WAIT or mid-DRAIN): return to IDLE.
  - Reset values: O_VLD=0, O_BUSY=0, O_ROW all 0, O_ROW_IDX=0, O_LAST=0, O_SA_CLR=0, O_DONE=0, snapshot buffer 0.
  - A partially drained tile is discarded.

## Timing
- I_START sampled at cycle 0: O_BUSY=1 from cycle 1.
- Nth I_SHIFT sampled at cycle c: CAPTURE during cycle c+1, first O_VLD at cycle c+2.
- With I_K=0: CAPTURE at cycle 1, O_VLD at cycle 2.
- With I_RDY held high: SA_R consecutive beats. CLR at the cycle after the last beat; IDLE (O_BUSY=0) the cycle after CLR.
- A new I_START is accepted on the first IDLE cycle.
- All outputs are registered except O_LAST and the optional O_ROW_MAX, which are decoded from registered state.

## Configuration
- SA_DRAIN_ROW_MAX_EN defined:
  - Adds output O_ROW_MAX (D_W): the signed maximum of O_ROW.
  - Valid whenever O_VLD; held stable under backpressure; 0 at reset.
  - Feeds softmax max-subtraction.
- Macro undefined: the port and the max logic are absent. All other behaviour is identical.

## Structure
- The shared package mha_pkg holds:
  - typedef enum sa_drain_state_t {IDLE, WAIT, CAPTURE, DRAIN, CLR}
  - the Q2.13 format constants (DATA_W, FRAC_W)
- Sub-module sa_row_max: combinational signed-max tree over SA_C words of D_W. It is instantiated only under SA_DRAIN_ROW_MAX_EN.

## Test plan
- SA_R=SA_C=4, I_K=3, I_SHIFT every 5 cycles, I_RDY=1 -> capture after the 10th pulse; 4 beats in order, O_ROW_IDX 0..3, O_LAST on beat 3; O_SA_CLR/O_DONE one cycle after beat 3.
- Same tile, I_RDY toggles 1,0,0,1,... -> O_ROW and O_ROW_IDX stable during stalls; exactly 4 transfers, no duplicates or skips.
- I_K=0 with I_SA_OUT all 0 -> O_VLD at cycle 2, four zero rows, no I_SHIFT needed.
- Second I_START during WAIT, and I_SHIFT pulses in IDLE -> both ignored; the capture count is unaffected.
- I_SYNC_RSTN low for 1 cycle after beat 1 -> next cycle O_VLD=0, O_BUSY=0, all outputs 0; the next I_START runs a full tile correctly.
- With SA_DRAIN_ROW_MAX_EN, row {16'hE000, 16'h0800, 16'h7FFF, 16'h8000} -> O_ROW_MAX = 16'h7FFF; row of all 16'hF000 -> 16'hF000.
